seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scanning, shadow/display
// double buffering committed only at frame boundaries, and optional leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] display_q, display_d;
  logic          pending_q, pending_d;
  logic          frame_done_q;
  logic          lz_q;
  logic          tick;
  logic          frame_boundary;
  logic          upper_zero;
  logic          blank;

  assign tick           = (cnt_q == CNT_LAST);
  assign frame_boundary = tick && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // Commit uses the pre-load shadow; a coincident load then re-arms pending.
    if (frame_boundary && pending_q) display_d = shadow_q;
    if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end else if (frame_boundary) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      lz_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_boundary;
      lz_q         <= lz_blank;
    end
  end

  // Digit idx is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (display_q[4*j +: 4] != 4'd0)) upper_zero = 1'b0;
    end
  end

  assign blank      = lz_q && (idx_q != '0) && upper_zero;
  assign bcd_out    = display_q[{idx_q, 2'b00} +: 4];
  assign digit_en   = blank ? {NUM_DIGITS{1'b1}} : ~(NUM_DIGITS'(1) << idx_q);
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
